// File: rtl/stream_demux.sv
// 1-to-NCH valid/ready demultiplexer with a single-beat output slot per channel,
// broadcast mode, and a saturating counter for beats whose select is out of range.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   drop_pulse
);

  logic [NCH-1:0]   free;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   drain;
  logic             sel_ok;
  logic             free_sel;
  logic             acc;
  logic             drop;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic             drop_pulse_reg;

  assign sel_ok = ({1'b0, in_sel} < (SEL_W + 1)'(NCH));

  // Mux free[] by in_sel without indexing past NCH when 2^SEL_W > NCH.
  always_comb begin
    free_sel = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (in_sel == SEL_W'(k)) free_sel = free[k];
    end
  end

  always_comb begin
    in_ready = 1'b1;
    if (in_bcast)    in_ready = &free;
    else if (sel_ok) in_ready = free_sel;
  end

  assign acc  = in_valid & in_ready;
  assign drop = acc & ~in_bcast & ~sel_ok;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
    logic             slot_valid_reg;
    logic [WIDTH-1:0] slot_data_reg;

    assign free[gi]  = ~slot_valid_reg | out_ready[gi];
    assign drain[gi] = slot_valid_reg & out_ready[gi];
    assign load[gi]  = acc & (in_bcast | (in_sel == SEL_W'(gi)));

    // An empty slot always shows zero data, so a drain without reload clears it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_valid_reg <= 1'b0;
        slot_data_reg  <= '0;
      end else if (load[gi]) begin
        slot_valid_reg <= 1'b1;
        slot_data_reg  <= in_data;
      end else if (drain[gi]) begin
        slot_valid_reg <= 1'b0;
        slot_data_reg  <= '0;
      end
    end

    assign out_valid[gi]                = slot_valid_reg;
    assign out_data[gi*WIDTH +: WIDTH]  = slot_data_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg   <= '0;
      drop_pulse_reg <= 1'b0;
    end else begin
      drop_pulse_reg <= drop;
      if (drop && (drop_cnt_reg != {CNT_W{1'b1}}))
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
    end
  end

  assign drop_cnt   = drop_cnt_reg;
  assign drop_pulse = drop_pulse_reg;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance for the datapath scenarios
// and a 3-channel instance to exercise the out-of-range drop path.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_bcast = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [7:0]  drop_cnt;
  logic        drop_pulse;

  logic [7:0]  in3_data = '0;
  logic [1:0]  in3_sel = '0;
  logic        in3_bcast = 1'b0;
  logic        in3_valid = 1'b0;
  logic        in3_ready;
  logic [23:0] out3_data;
  logic [2:0]  out3_valid;
  logic [2:0]  out3_ready = '0;
  logic [7:0]  drop3_cnt;
  logic        drop3_pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(8), .NCH(4), .SEL_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
  );

  stream_demux #(.WIDTH(8), .NCH(3), .SEL_W(2), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in3_data), .in_sel(in3_sel), .in_bcast(in3_bcast),
    .in_valid(in3_valid), .in_ready(in3_ready),
    .out_data(out3_data), .out_valid(out3_valid), .out_ready(out3_ready),
    .drop_cnt(drop3_cnt), .drop_pulse(drop3_pulse)
  );

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%h exp=0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++;
    if (drop_cnt !== 8'h0 || drop_pulse !== 1'b0) begin
      failures++; $display("FAIL reset_drop got cnt=%h pulse=%b exp cnt=0 pulse=0", drop_cnt, drop_pulse);
    end
    $display("reset: out_valid=%h out_data=%h drop_cnt=%0d", out_valid, out_data, drop_cnt);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unicast();
    logic [31:0] exp;
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_bcast = 1'b0; in_sel = 2'(k); in_data = 8'hA0 + 8'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL uni_ready ch=%0d got=%b exp=1", k, in_ready); end
      @(posedge clk); #1;
      exp = '0;
      exp[k*8 +: 8] = 8'hA0 + 8'(k);
      checks++;
      if (out_valid !== 4'(1 << k) || out_data !== exp) begin
        failures++; $display("FAIL uni_out ch=%0d got v=%h d=%h exp v=%h d=%h", k, out_valid, out_data, 4'(1 << k), exp);
      end
      $display("unicast ch=%0d data=%h out_valid=%h out_data=%h", k, in_data, out_valid, out_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'h0 || out_data !== 32'h0) begin
      failures++; $display("FAIL uni_drain got v=%h d=%h exp v=0 d=0", out_valid, out_data);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011;
    @(negedge clk);
    in_valid = 1'b1; in_bcast = 1'b0; in_sel = 2'd2; in_data = 8'h11;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h11) begin
      failures++; $display("FAIL bp_load1 got v=%h d=%h exp v=4 d=11", out_valid, out_data[23:16]);
    end
    @(negedge clk);
    in_data = 8'h22;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h11) begin
      failures++; $display("FAIL bp_hold got v=%h d=%h exp v=4 d=11", out_valid, out_data[23:16]);
    end
    @(negedge clk);
    out_ready = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready2 got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h22) begin
      failures++; $display("FAIL bp_replace got v=%h d=%h exp v=4 d=22", out_valid, out_data[23:16]);
    end
    $display("backpressure: ch2 data=%h out_valid=%h", out_data[23:16], out_valid);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'h0) begin failures++; $display("FAIL bp_drain got=%h exp=0", out_valid); end
  endtask

  task automatic test_bcast_stall();
    out_ready = 4'b1101;
    @(negedge clk);
    in_valid = 1'b1; in_bcast = 1'b0; in_sel = 2'd1; in_data = 8'h33;
    @(posedge clk);
    @(negedge clk);
    in_bcast = 1'b1; in_sel = 2'd2; in_data = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bc_stall cyc=%0d got=%b exp=0", i, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 4'b0010 || out_data !== 32'h0000_3300) begin
        failures++; $display("FAIL bc_hold cyc=%0d got v=%h d=%h exp v=2 d=00003300", i, out_valid, out_data);
      end
      @(negedge clk);
    end
    out_ready = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bc_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'hF || out_data !== 32'h5A5A_5A5A) begin
      failures++; $display("FAIL bc_out got v=%h d=%h exp v=f d=5a5a5a5a", out_valid, out_data);
    end
    $display("broadcast: out_valid=%h out_data=%h", out_valid, out_data);
    @(negedge clk);
    in_valid = 1'b0; in_bcast = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nonblocking();
    out_ready = 4'b1110;
    @(negedge clk);
    in_valid = 1'b1; in_bcast = 1'b0; in_sel = 2'd0; in_data = 8'h77;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_sel = 2'd3; in_data = 8'hC0 + 8'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL nb_ready i=%0d got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 4'b1001 || out_data[31:24] !== 8'hC0 + 8'(i) || out_data[7:0] !== 8'h77) begin
        failures++; $display("FAIL nb_out i=%0d got v=%h d=%h exp v=9 ch3=%h ch0=77", i, out_valid, out_data, 8'hC0 + 8'(i));
      end
      $display("nonblocking: ch3 data=%h out_valid=%h", out_data[31:24], out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'h0 || out_data !== 32'h0) begin
      failures++; $display("FAIL nb_drain got v=%h d=%h exp 0", out_valid, out_data);
    end
  endtask

  task automatic test_drop();
    logic [7:0] exp_cnt;
    out3_ready = 3'b111;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      in3_valid = 1'b1; in3_bcast = 1'b0; in3_sel = 2'd3; in3_data = 8'(i);
      #1;
      checks++;
      if (in3_ready !== 1'b1) begin failures++; $display("FAIL drop_ready i=%0d got=%b exp=1", i, in3_ready); end
      @(posedge clk); #1;
      exp_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      checks++;
      if (drop3_pulse !== 1'b1 || out3_valid !== 3'b000 || drop3_cnt !== exp_cnt) begin
        failures++; $display("FAIL drop_beat i=%0d got p=%b v=%h c=%0d exp p=1 v=0 c=%0d", i, drop3_pulse, out3_valid, drop3_cnt, exp_cnt);
      end
    end
    $display("drop: 260 beats, drop_cnt=%0d", drop3_cnt);
    @(negedge clk);
    in3_bcast = 1'b1; in3_data = 8'h99;
    #1;
    checks++;
    if (in3_ready !== 1'b1) begin failures++; $display("FAIL drop_bc_ready got=%b exp=1", in3_ready); end
    @(posedge clk); #1;
    checks++;
    if (out3_valid !== 3'b111 || out3_data !== 24'h99_9999 || drop3_pulse !== 1'b0 || drop3_cnt !== 8'd255) begin
      failures++; $display("FAIL drop_bcast got v=%h d=%h p=%b c=%0d exp v=7 d=999999 p=0 c=255", out3_valid, out3_data, drop3_pulse, drop3_cnt);
    end
    @(negedge clk);
    in3_valid = 1'b0; in3_bcast = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out3_valid !== 3'b000 || drop3_pulse !== 1'b0) begin
      failures++; $display("FAIL drop_idle got v=%h p=%b exp v=0 p=0", out3_valid, drop3_pulse);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 4'h0;
    @(negedge clk);
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'hAA;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'hF || out_data !== 32'hAAAA_AAAA) begin
      failures++; $display("FAIL ar_fill got v=%h d=%h exp v=f d=aaaaaaaa", out_valid, out_data);
    end
    @(negedge clk);
    in_valid = 1'b0; in_bcast = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'h0 || out_data !== 32'h0 || drop3_cnt !== 8'h0 || out3_valid !== 3'b000) begin
      failures++; $display("FAIL ar_clear got v=%h d=%h c3=%0d v3=%h exp all 0", out_valid, out_data, drop3_cnt, out3_valid);
    end
    $display("async reset: out_valid=%h out_data=%h drop_cnt3=%0d", out_valid, out_data, drop3_cnt);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'h0) begin failures++; $display("FAIL ar_after got=%h exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_bcast_stall();
    test_nonblocking();
    test_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
